// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one synchronous memory port between two masters:
//   requester 0 is the CPU and requester 1 is the loader/debug master.
//   Each access runs IDLE -> ISSUE -> WAIT (WAIT_STATES cycles, skipped when 0)
//   -> CAPTURE -> ACK -> IDLE. Arbitration is round-robin, and a requester
//   may hold a lock for up to MAX_LOCK back-to-back grants.
//
//   Ports
//     clock, reset        rising-edge clock; asynchronous active-high reset
//     req[1:0]            per-requester request, held until ack
//     lock[1:0]           per-requester request to keep ownership
//     addr0/1, wdata0/1,  per-requester request fields, latched in IDLE
//     we0/1
//     ack[1:0]            one-cycle completion pulse to the owner
//     rdata               read data, valid while ack is high, held until next capture
//     grant[1:0]          one-hot owner, 0 when idle
//     busy                high in every state except IDLE
//     mem_addr/wdata/we   memory controller request
//     mem_rdata           memory read data, valid the cycle after the address
//
//   Optional: define MEM_ARB_PERF_EN to add perf_clr and the saturating
//   per-requester ack counters cnt0/cnt1.

`ifdef MEM_ARB_PERF_EN
// Counts ack pulses for one requester. The counter saturates at all-ones.
// A clear takes priority over an increment in the same cycle.
module mem_arb_sat_cnt (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clock or posedge reset)
    if (reset)                      cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && (cnt != '1))    cnt <= cnt + 16'd1;
endmodule
`endif

module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int MAX_LOCK    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
`ifdef MEM_ARB_PERF_EN
  input  logic              perf_clr,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1,
`endif
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_ACK} state_t;

  // When WAIT_STATES is 0, the WAIT state is never entered and WS_LAST is unused.
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);
  localparam logic [7:0] MAX_LK  = 8'(MAX_LOCK);

  state_t                   state, state_nxt;
  logic [3:0]               wait_cnt;
  logic [7:0]               lock_cnt;
  logic                     last_grant;   // index of the previous owner
  logic                     we_q;
  logic [1:0]               grant_q;
  logic                     win;          // index of the requester that wins in IDLE
  logic                     lock_win;

  // Per-requester request fields, packed so the winner index selects them directly.
  logic [1:0][ADDR_W-1:0]   addr_v;
  logic [1:0][DATA_W-1:0]   wdata_v;
  logic [1:0]               we_v;

  assign addr_v  = {addr1, addr0};
  assign wdata_v = {wdata1, wdata0};
  assign we_v    = {we1, we0};

  // The previous owner keeps the bus while it holds lock and has quota left.
  // Otherwise the other requester takes priority whenever it is asking.
  always_comb begin
    lock_win = req[last_grant] && lock[last_grant] && (lock_cnt < MAX_LK);
    if (lock_win)              win = last_grant;
    else if (req[~last_grant]) win = ~last_grant;
    else                       win = last_grant;
  end

  // State register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req != 2'b00) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (WAIT_STATES == 0) ? S_CAPT : S_WAIT;
      S_WAIT:  if (wait_cnt == WS_LAST) state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs. These are decoded from the state, so a reset clears mem_we and ack at once.
  always_comb begin
    ack    = 2'b00;
    mem_we = 1'b0;
    busy   = (state != S_IDLE);
    case (state)
      S_ISSUE: mem_we = we_q;
      S_ACK:   ack    = grant_q;
      default: ;
    endcase
  end

  assign grant = grant_q;

  // Datapath and arbitration state
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      grant_q    <= 2'b00;
      last_grant <= 1'b1;      // the CPU wins the first tie
      lock_cnt   <= '0;
      wait_cnt   <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        S_IDLE: if (req != 2'b00) begin
          mem_addr  <= addr_v[win];
          mem_wdata <= wdata_v[win];
          we_q      <= we_v[win];
          grant_q   <= win ? 2'b10 : 2'b01;
          // A locked regrant counts up, saturating at the quota.
          // Any other grant restarts the count, at 1 if that grant is itself locked.
          if ((win == last_grant) && lock[win])
            lock_cnt <= (lock_cnt < MAX_LK) ? lock_cnt + 8'd1 : lock_cnt;
          else
            lock_cnt <= {7'd0, lock[win]};
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT:  wait_cnt <= wait_cnt + 4'd1;
        S_CAPT:  rdata    <= mem_rdata;
        S_ACK: begin
          last_grant <= grant_q[1];
          grant_q    <= 2'b00;
        end
        default: ;
      endcase
    end

`ifdef MEM_ARB_PERF_EN
  logic [1:0][15:0] cnt_v;
  for (genvar i = 0; i < 2; i++) begin : g_perf
    mem_arb_sat_cnt u_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (perf_clr),
      .inc   (ack[i]),
      .cnt   (cnt_v[i])
    );
  end
  assign cnt0 = cnt_v[0];
  assign cnt1 = cnt_v[1];
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int WS_B     = 3;
  localparam int MAX_LOCK = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, rst_b;
  logic [1:0]  req, lock;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        we0, we1;
  logic [1:0]  ack_a, ack_b, grant_a, grant_b;
  logic        busy_a, busy_b, mem_we_a, mem_we_b;
  logic [31:0] rdata_a, rdata_b, mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
  logic [15:0] mem_addr_a, mem_addr_b;
`ifdef MEM_ARB_PERF_EN
  logic        perf_clr;
  logic [15:0] cnt0_a, cnt1_a, cnt0_b, cnt1_b;
`endif

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_STATES(0), .MAX_LOCK(MAX_LOCK)) dut_a (
    .clock(clock), .reset(rst_a), .req(req), .lock(lock),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
`ifdef MEM_ARB_PERF_EN
    .perf_clr(perf_clr), .cnt0(cnt0_a), .cnt1(cnt1_a),
`endif
    .ack(ack_a), .rdata(rdata_a), .grant(grant_a), .busy(busy_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .mem_rdata(mem_rdata_a)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_STATES(WS_B), .MAX_LOCK(MAX_LOCK)) dut_b (
    .clock(clock), .reset(rst_b), .req(req), .lock(lock),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
`ifdef MEM_ARB_PERF_EN
    .perf_clr(perf_clr), .cnt0(cnt0_b), .cnt1(cnt1_b),
`endif
    .ack(ack_b), .rdata(rdata_b), .grant(grant_b), .busy(busy_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rdata(mem_rdata_b)
  );

  // The "view" signals follow whichever DUT is under test. The other DUT is held in reset.
  bit use_b;
  logic [1:0]  v_ack, v_grant;
  logic        v_busy, v_mem_we;
  logic [31:0] v_rdata, v_mem_wdata;
  logic [15:0] v_mem_addr;
  assign v_ack       = use_b ? ack_b       : ack_a;
  assign v_grant     = use_b ? grant_b     : grant_a;
  assign v_busy      = use_b ? busy_b      : busy_a;
  assign v_mem_we    = use_b ? mem_we_b    : mem_we_a;
  assign v_rdata     = use_b ? rdata_b     : rdata_a;
  assign v_mem_wdata = use_b ? mem_wdata_b : mem_wdata_a;
  assign v_mem_addr  = use_b ? mem_addr_b  : mem_addr_a;

  // Synchronous memories. Read data is registered from the address of the previous cycle.
  bit [31:0]   mem_a [1024];
  bit [31:0]   mem_b [1024];
  logic        pl_en;
  logic [9:0]  pl_a;
  logic [31:0] pl_d;
  always @(posedge clock) begin
    if (pl_en) begin
      mem_a[pl_a] <= pl_d;
      mem_b[pl_a] <= pl_d;
    end else begin
      if (mem_we_a) mem_a[mem_addr_a[9:0]] <= mem_wdata_a;
      if (mem_we_b) mem_b[mem_addr_b[9:0]] <= mem_wdata_b;
    end
    mem_rdata_a <= mem_a[mem_addr_a[9:0]];
    mem_rdata_b <= mem_b[mem_addr_b[9:0]];
  end

  logic [31:0] mm [2][1024];   // expected memory contents per DUT
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for ack at %0t", nm, $time);
  endtask

  task automatic set_req(input int r, input logic w, input logic [15:0] a, input logic [31:0] d);
    if (r == 0) begin addr0 = a; wdata0 = d; we0 = w; end
    else        begin addr1 = a; wdata1 = d; we1 = w; end
  endtask

  // Resets the selected DUT, holds the other in reset, and checks the reset state.
  task automatic do_reset(input bit b);
    req = 2'b00; lock = 2'b00; use_b = b;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    if (b) rst_b = 1'b0; else rst_a = 1'b0;
    @(negedge clock);
    chk("rst_ack", v_ack, 2'b00);
    chk("rst_grant", v_grant, 2'b00);
    chk("rst_busy", v_busy, 1'b0);
    chk("rst_rdata", v_rdata, 32'h0);
    chk("rst_mem_addr", v_mem_addr, 16'h0);
    chk("rst_mem_we", v_mem_we, 1'b0);
    @(posedge clock); #1;
  endtask

  // Performs one single-requester access, checking issue, latency, rdata and the write pulse.
  task automatic do_access(input int r, input logic w, input logic [15:0] a,
                           input logic [31:0] d, input logic [31:0] exp);
    logic [1:0] oh;
    int ws, wecnt;
    bit got;
    oh = (r == 0) ? 2'b01 : 2'b10;
    ws = use_b ? WS_B : 0;
    wecnt = 0; got = 0;
    lock = 2'b00; req = oh; set_req(r, w, a, d);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      if (v_mem_we) wecnt++;
      if (k == 1) begin
        chk("issue_addr", v_mem_addr, a);
        chk("issue_grant", v_grant, oh);
      end
      if (v_ack != 2'b00) begin
        got = 1;
        chk("ack_who", v_ack, oh);
        chk("ack_latency", k, 3 + ws);
        if (!w) chk("rdata", v_rdata, exp);
      end
      @(posedge clock); #1;
    end
    req = 2'b00;
    if (!got) timeout("do_access");
    chk("we_pulses", wecnt, w);
    if (w) mm[use_b][a[9:0]] = d;
    @(negedge clock);
    chk("idle_grant", v_grant, 2'b00);
    chk("idle_busy", v_busy, 1'b0);
    @(posedge clock); #1;
  endtask

  // Both requesters ask continuously. Bit i of exp_idx is the expected owner of ack i.
  task automatic ack_seq(input string nm, input logic [1:0] lk, input int n, input logic [31:0] exp_idx);
    int got = 0;
    set_req(0, 1'b0, 16'h0010, 32'h0);
    set_req(1, 1'b0, 16'h0011, 32'h0);
    req = 2'b11; lock = lk;
    for (int k = 0; k < 200 && got < n; k++) begin
      @(negedge clock);
      if (v_ack != 2'b00) begin
        chk(nm, v_ack, exp_idx[got] ? 2'b10 : 2'b01);
        got++;
      end
      @(posedge clock); #1;
    end
    req = 2'b00; lock = 2'b00;
    if (got < n) timeout(nm);
    repeat (8) @(posedge clock);
    #1;
  endtask

  // Random traffic checked against a timeline model of the access sequence.
  // Each grant occupies cycles start+1..start+3+ws, with ack in the last cycle.
  task automatic run_random(input int ncyc);
    int ws, gstart, free_at, own, last, lcnt, g;
    logic [15:0] la;
    logic [31:0] ld, erd;
    logic lw, ebusy, ewe;
    logic [1:0] eack, egrant;
    bit done [2];
    ws = use_b ? WS_B : 0;
    gstart = -100; free_at = 0; own = 0; last = 1; lcnt = 0; g = 0;
    la = '0; ld = '0; erd = '0; lw = 1'b0;
    done[0] = 0; done[1] = 0;
    req = 2'b00; lock = 2'b00;
    for (int c = 0; c < ncyc; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req[r] || done[r]) begin
          done[r] = 0;
          if ($urandom_range(0, 2) != 0) begin
            req[r] = 1'b1;
            set_req(r, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom);
          end else req[r] = 1'b0;
        end else if (c > gstart && c < free_at && own == r) begin
          // The fields were latched at grant, so these changes must have no effect.
          set_req(r, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom);
        end
        if ($urandom_range(0, 7) == 0) lock[r] = ~lock[r];
      end
      @(negedge clock);
      ebusy  = (c > gstart) && (c < free_at);
      egrant = ebusy ? (own == 1 ? 2'b10 : 2'b01) : 2'b00;
      eack   = (c == free_at - 1) ? egrant : 2'b00;
      ewe    = (c == gstart + 1) && lw;
      chk("rnd_busy", v_busy, ebusy);
      chk("rnd_grant", v_grant, egrant);
      chk("rnd_ack", v_ack, eack);
      chk("rnd_mem_we", v_mem_we, ewe);
      if (ebusy) chk("rnd_mem_addr", v_mem_addr, la);
      if (ewe) chk("rnd_mem_wdata", v_mem_wdata, ld);
      if (eack != 2'b00) begin
        if (!lw) chk("rnd_rdata", v_rdata, erd);
        done[own] = 1;
      end
      if (c >= free_at && req != 2'b00) begin
        // Plain round robin first. A lock held within quota then overrides it.
        if (req == 2'b01)      g = 0;
        else if (req == 2'b10) g = 1;
        else                   g = 1 - last;
        if (req[last] && lock[last] && lcnt < MAX_LOCK) g = last;
        if (g == last && lock[g]) lcnt = (lcnt < MAX_LOCK) ? lcnt + 1 : lcnt;
        else                      lcnt = lock[g] ? 1 : 0;
        own = g; last = g; gstart = c; free_at = c + 4 + ws;
        la = (g == 1) ? addr1 : addr0;
        ld = (g == 1) ? wdata1 : wdata0;
        lw = (g == 1) ? we1 : we0;
        if (lw) mm[use_b][la[9:0]] = ld;
        else    erd = mm[use_b][la[9:0]];
      end
      @(posedge clock); #1;
    end
    req = 2'b00;
    repeat (ws + 6) @(posedge clock);
    #1;
  endtask

  typedef struct {
    int          r;
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1'b0, 16'h0010, 32'h0,         32'hDEADBEEF};
    tbl[1] = '{1, 1'b1, 16'h0100, 32'h12345678,  32'h0};
    tbl[2] = '{0, 1'b0, 16'h0100, 32'h0,         32'h12345678};
    tbl[3] = '{1, 1'b0, 16'h0010, 32'h0,         32'hDEADBEEF};
    tbl[4] = '{0, 1'b1, 16'h0020, 32'hA5A50F0F,  32'h0};
    tbl[5] = '{1, 1'b0, 16'h0020, 32'h0,         32'hA5A50F0F};
    tbl[6] = '{0, 1'b0, 16'h0030, 32'h0,         32'h0};

    rst_a = 1'b1; rst_b = 1'b1; use_b = 0;
    req = 2'b00; lock = 2'b00;
    set_req(0, 1'b0, 16'h0, 32'h0);
    set_req(1, 1'b0, 16'h0, 32'h0);
`ifdef MEM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) begin mm[0][i] = '0; mm[1][i] = '0; end
    pl_en = 1'b1; pl_a = 10'h010; pl_d = 32'hDEADBEEF;
    @(posedge clock); #1;
    pl_en = 1'b0;
    mm[0][16] = 32'hDEADBEEF; mm[1][16] = 32'hDEADBEEF;

    // Directed single accesses, no wait states
    do_reset(0);
    for (int i = 0; i < 7; i++) do_access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp);

    // Round robin without lock: the CPU goes first, then the owners alternate
    do_reset(0);
    ack_seq("rr_alternate", 2'b00, 6, 32'h0000_002A);

    // The loader holds a lock: 8 locked grants, then the CPU gets the bus
    do_reset(0);
    ack_seq("lock_quota", 2'b10, 9, 32'h0000_00FF);

`ifdef MEM_ARB_PERF_EN
    do_reset(0);
    for (int i = 0; i < 7; i++) do_access(i < 5 ? 0 : 1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF);
    @(negedge clock);
    chk("perf_cnt0", cnt0_a, 16'd5);
    chk("perf_cnt1", cnt1_a, 16'd2);
    @(posedge clock); #1 perf_clr = 1'b1;
    @(posedge clock); #1 perf_clr = 1'b0;
    @(negedge clock);
    chk("perf_clr0", cnt0_a, 16'd0);
    chk("perf_clr1", cnt1_a, 16'd0);
    @(posedge clock); #1;
`endif

    do_reset(0);
    run_random(1500);

    // Three wait states: reset asserted during WAIT aborts the access with no ack
    do_reset(1);
    set_req(0, 1'b0, 16'h0010, 32'h0);
    req = 2'b01;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("wait_busy", v_busy, 1'b1);
    chk("wait_we", v_mem_we, 1'b0);
    chk("wait_grant", v_grant, 2'b01);
    #2 rst_b = 1'b1;
    #1;
    chk("abort_ack", v_ack, 2'b00);
    chk("abort_grant", v_grant, 2'b00);
    chk("abort_busy", v_busy, 1'b0);
    chk("abort_addr", v_mem_addr, 16'h0);
    repeat (2) begin
      @(negedge clock);
      chk("abort_noack", v_ack, 2'b00);
    end
    @(posedge clock); #1 rst_b = 1'b0;
    do_access(0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF);

    // Reset in ISSUE of a write drops mem_we at once, so memory is not written
    set_req(1, 1'b1, 16'h0040, 32'h5555AAAA);
    req = 2'b10;
    @(posedge clock); #1;
    @(negedge clock);
    chk("issue_we", v_mem_we, 1'b1);
    #2 rst_b = 1'b1;
    #1;
    chk("abort_we", v_mem_we, 1'b0);
    req = 2'b00;
    repeat (2) @(posedge clock);
    #1 rst_b = 1'b0;
    do_access(1, 1'b0, 16'h0040, 32'h0, 32'h0);

    do_reset(1);
    run_random(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
